// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU issue controller.
// Select encodings match the ALU's select input; ALU_NOP lands in the ALU's zero-producing default case.
package alu_pkg;

    localparam int XLEN_DEFAULT = 64;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_NOP = 2'b11
    } alu_sel_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of opcode/funct3/funct7 into ALU select, operand-2 source and illegal flag.
// Anything outside the ADD/SUB/ADDI subset is illegal and routed to ALU_NOP.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output alu_sel_e   o_sel,
    output logic       o_use_imm,
    output logic       o_illegal
);

    always_comb begin
        o_sel     = ALU_NOP;
        o_use_imm = 1'b0;
        o_illegal = 1'b1;
        if (i_opcode == OPC_OP && i_funct3 == F3_ADD_SUB && i_funct7 == F7_BASE) begin
            o_sel     = ALU_ADD;
            o_illegal = 1'b0;
        end else if (i_opcode == OPC_OP && i_funct3 == F3_ADD_SUB && i_funct7 == F7_ALT) begin
            o_sel     = ALU_SUB;
            o_illegal = 1'b0;
        end else if (i_opcode == OPC_OP_IMM && i_funct3 == F3_ADD_SUB) begin
            o_sel     = ALU_ADD;
            o_use_imm = 1'b1;
            o_illegal = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: S1 drives the ALU operands/select from registers,
// S2 captures the ALU result for writeback. Two-stage valid/ready pipeline with backpressure.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_funct3,
    input  logic [6:0]       in_funct7,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [4:0]       in_rd,
    output logic [XLEN-1:0]  alu_in1,
    output logic [XLEN-1:0]  alu_in2,
    output logic [1:0]       alu_sel,
    input  logic [XLEN-1:0]  alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    alu_sel_e          w_dec_sel;
    logic              w_dec_use_imm;
    logic              w_dec_illegal;

    logic              r_s1_valid;
    logic [XLEN-1:0]   r_alu_in1;
    logic [XLEN-1:0]   r_alu_in2;
    alu_sel_e          r_alu_sel;
    logic [4:0]        r_s1_rd;
    logic              r_s1_illegal;

    logic              r_out_valid;
    logic [XLEN-1:0]   r_out_data;
    logic [4:0]        r_out_rd;
    logic              r_out_illegal;
    logic [CNT_W-1:0]  r_retired_cnt;

    logic              w_s2_free;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_advance;
    logic              w_retire;

    alu_op_decode u_decode (
        .i_opcode  (in_opcode),
        .i_funct3  (in_funct3),
        .i_funct7  (in_funct7),
        .o_sel     (w_dec_sel),
        .o_use_imm (w_dec_use_imm),
        .o_illegal (w_dec_illegal)
    );

    // S2 can take a new entry when empty or draining this cycle; that drain also frees S1.
    assign w_s2_free  = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_accept   = in_valid && w_in_ready && !flush;
    assign w_advance  = r_s1_valid && w_s2_free;
    assign w_retire   = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_alu_in1    <= '0;
            r_alu_in2    <= '0;
            r_alu_sel    <= ALU_NOP;
            r_s1_rd      <= '0;
            r_s1_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_accept) begin
                r_alu_in1    <= in_rs1;
                r_alu_in2    <= w_dec_use_imm ? in_imm : in_rs2;
                r_alu_sel    <= w_dec_sel;
                r_s1_rd      <= in_rd;
                r_s1_illegal <= w_dec_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_rd      <= '0;
            r_out_illegal <= 1'b0;
        end else begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_s2_free) begin
                r_out_valid <= r_s1_valid;
            end
            if (w_advance && !flush) begin
                r_out_data    <= r_s1_illegal ? '0 : alu_result;
                r_out_rd      <= r_s1_rd;
                r_out_illegal <= r_s1_illegal;
            end
        end
    end

    // A writeback handshake completing in a flush cycle still counts as retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired_cnt <= '0;
        end else if (w_retire) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign alu_in1     = r_alu_in1;
    assign alu_in2     = r_alu_in2;
    assign alu_sel     = r_alu_sel;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_rd      = r_out_rd;
    assign out_illegal = r_out_illegal;
    assign retired_cnt = r_retired_cnt;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Issue-side controller for the 64-bit ALU; it is the producer end of the ALU operand/select interface.
- Accepts decoded instruction fields from decode through a valid/ready handshake.
- Derives the 2-bit ALU select, chooses operands, drives the ALU's operand and select inputs from registers, and captures the ALU result into a writeback register.
- Sits between decode and writeback in the execute stage. It is a 2-stage pipeline (operand stage S1, result stage S2) with backpressure.

Parameters:
- XLEN, 64, datapath width; must match the ALU operand width.
- CNT_W, 32, width of the retired-op counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous squash of S1 and S2 contents.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  controller accepts an op this cycle.
- in_opcode  in  7  RV opcode.
- in_funct3  in  3  funct3.
- in_funct7  in  7  funct7.
- in_rs1  in  XLEN  rs1 value.
- in_rs2  in  XLEN  rs2 value.
- in_imm  in  XLEN  sign-extended immediate.
- in_rd  in  5  destination register.
- alu_in1  out  XLEN  to ALU operand 1.
- alu_in2  out  XLEN  to ALU operand 2.
- alu_sel  out  2  to ALU select.
- alu_result  in  XLEN  from ALU output (combinational).
- out_valid  out  1  writeback entry valid.
- out_ready  in  1  writeback accepts.
- out_data  out  XLEN  captured result.
- out_rd  out  5  destination register.
- out_illegal  out  1  op was not decodable; out_data forced 0.
- retired_cnt  out  CNT_W  ops handed to writeback.

Behaviour:
- Decode (combinational on in_* fields):
  - OP (0110011), f3=000, f7=0000000: ADD, sel 2'b00, operand 2 = rs2.
  - OP, f3=000, f7=0100000: SUB, sel 2'b01, operand 2 = rs2.
  - OP-IMM (0010011), f3=000: ADD, sel 2'b00, operand 2 = imm.
  - Anything else: illegal=1, sel 2'b11; the ALU's default case yields 0.
- S1 register (s1_valid, alu_in1, alu_in2, alu_sel, rd, illegal): loaded at a clock edge when in_valid && in_ready. alu_* ports are driven straight from S1 registers and hold steady while S1 is stalled.
- S2 register (out_valid, out_data, out_rd, out_illegal): loaded from S1 when s1_valid && s2_free. out_data takes alu_result, or 0 if illegal.
- s2_free = !out_valid || out_ready.
- in_ready = !s1_valid || s2_free (combinational; no dependence on in_valid).
- Latency: an op accepted at edge N presents out_valid from edge N+2 when unstalled. Throughput is 1 op/cycle while out_ready=1.
- Hold rule: out_* stay stable while out_valid && !out_ready. A stalled S1 keeps its contents and in_ready=0.
- Simultaneous S2 drain and S1 refill in one cycle is mandatory; no bubble is allowed.
- retired_cnt increments by 1 on each out_valid && out_ready, including illegal ops, and wraps modulo 2^CNT_W.
- flush:
  - On the next edge, s1_valid=0 and out_valid=0.
  - An input handshake in the flush cycle is dropped.
  - retired_cnt still counts a handshake completing in that same cycle.
- Reset (async assert, sync-released deassert path is external):
  - s1_valid=0, out_valid=0, alu_in1=0, alu_in2=0, alu_sel=2'b11, out_data=0, out_rd=0, out_illegal=0, retired_cnt=0.
  - in_ready=1 immediately after reset.
  - Reset mid-operation discards all in-flight ops.
- Pipeline state encoding (derived from the valid bits): EMPTY(00), S1 only(10), S2 only(01), FULL(11).
  - FULL && !out_ready: hold.
  - FULL && out_ready && in_valid: stay FULL (stream).

Decomposition:
- Package alu_pkg:
  - alu_sel_e enum: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_NOP=2'b11.
  - Opcode constants OPC_OP, OPC_OP_IMM.
  - Funct7 constants F7_BASE, F7_ALT.
  - XLEN default.
- Sub-module alu_op_decode: combinational mapping of opcode/f3/f7 to {sel, use_imm, illegal}.
- Top level instantiates alu_op_decode; the ALU itself is instantiated alongside it at stage level.

Test Plan:
- ADD reg: rs1=5, rs2=7, OP/000/0000000, out_ready=1.
  - Expect alu_sel=00, alu_in1=5, alu_in2=7 in cycle N+1.
  - Expect out_valid with out_data = ALU result (ALU stub returning in1+in2 gives 12) at N+2.
  - Expect retired_cnt=1.
- OP-IMM: rs1=0xFFFF_FFFF_FFFF_FFFF, imm=1.
  - Expect alu_in2=1, alu_sel=00.
  - Expect out_data = result with wrap; stub gives 0.
- Illegal opcode 0000011.
  - Expect alu_sel=11, out_illegal=1, out_data=0.
  - Expect retired_cnt to increment.
- Backpressure: stream 4 ops with out_ready=0 from cycle 2.
  - Expect in_ready=0 once FULL, out_* stable, no op lost.
  - After raising out_ready, expect 4 results in order on 4 consecutive cycles.
- flush with FULL pipe.
  - Expect out_valid=0 and in_ready=1 next cycle.
  - A concurrent in handshake is dropped and retired_cnt is unchanged.
- Async reset asserted mid-stream.
  - Expect all outputs at their reset values without waiting for a clock edge.
  - First op after release completes with 2-cycle latency.
